// File: rtl/fp32_addsub_arbiter_pkg.sv
// rtl/fp32_addsub_arbiter_pkg.sv - shared fp32 constants and helpers for the adder arbiter
package fp32_addsub_arbiter_pkg;

  localparam int FP32_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [FP32_W-1:0] FP32_ONE  = 32'h3F80_0000;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp32_arb_tag_fifo.sv
// rtl/fp32_arb_tag_fifo.sv - in-order FIFO of requester IDs for operations in flight
module fp32_arb_tag_fifo
  import fp32_addsub_arbiter_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDW   = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic [IDW-1:0]           i_push_id,
  input  logic                     i_pop,
  output logic [clog2(DEPTH):0]    o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [IDW-1:0]           o_head
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [IDW-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  // A pop on an empty FIFO is dropped; the top reports it as underflow.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + (AW + 1)'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_id;
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/fp32_addsub_arbiter.sv
// rtl/fp32_addsub_arbiter.sv - round-robin sharing of one pipelined fp32 add/sub unit
module fp32_addsub_arbiter
  import fp32_addsub_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int IDW   = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*FP32_W-1:0]   req_a,
  input  logic [NREQ*FP32_W-1:0]   req_b,
  input  logic [NREQ-1:0]          req_op,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     hold,
  output logic [FP32_W-1:0]        add_dina,
  output logic [FP32_W-1:0]        add_dinb,
  output logic                     add_op,
  output logic                     add_valid_in,
  input  logic [FP32_W-1:0]        add_result,
  input  logic                     add_valid_out,
  output logic                     res_valid,
  output logic [IDW-1:0]           res_id,
  output logic [FP32_W-1:0]        res_data,
  output logic                     busy,
  output logic                     err_underflow
);

  localparam int CW = clog2(DEPTH) + 1;

  logic [IDW-1:0]    r_last;
  logic [FP32_W-1:0] r_add_dina;
  logic [FP32_W-1:0] r_add_dinb;
  logic              r_add_op;
  logic              r_add_valid_in;
  logic              r_res_valid;
  logic [IDW-1:0]    r_res_id;
  logic [FP32_W-1:0] r_res_data;
  logic              r_busy;
  logic              r_err_underflow;

  logic [CW-1:0]     w_count;
  logic              w_empty;
  logic              w_full;
  logic [IDW-1:0]    w_head;
  logic              w_eligible;
  logic              w_found;
  logic [IDW-1:0]    w_idx;
  logic [IDW-1:0]    w_grant_id;
  logic [NREQ-1:0]   w_grant;
  logic              w_transfer;
  logic [FP32_W-1:0] w_sel_a;
  logic [FP32_W-1:0] w_sel_b;
  logic              w_sel_op;
  logic              w_pop_ok;

  // Eligibility ignores add_valid_out so a same-cycle pop never opens a full FIFO.
  assign w_eligible = rstn && !hold && !w_full;

  always_comb begin
    w_found    = 1'b0;
    w_idx      = r_last;
    w_grant_id = r_last;
    w_grant    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(r_last) + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found    = 1'b1;
        w_grant_id = w_idx;
      end
    end
    if (w_found && w_eligible) w_grant[w_grant_id] = 1'b1;
  end

  assign req_ready  = w_grant;
  assign w_transfer = w_found && w_eligible;

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = OP_ADD;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_id == IDW'(i)) begin
        w_sel_a  = req_a[i*FP32_W +: FP32_W];
        w_sel_b  = req_b[i*FP32_W +: FP32_W];
        w_sel_op = req_op[i];
      end
    end
  end

  assign w_pop_ok = add_valid_out && !w_empty;

  fp32_arb_tag_fifo #(
    .DEPTH (DEPTH),
    .IDW   (IDW)
  ) u_tag_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .i_push    (w_transfer),
    .i_push_id (w_grant_id),
    .i_pop     (add_valid_out),
    .o_count   (w_count),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_head    (w_head)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last          <= IDW'(NREQ - 1);
      r_add_dina      <= '0;
      r_add_dinb      <= '0;
      r_add_op        <= 1'b0;
      r_add_valid_in  <= 1'b0;
      r_res_valid     <= 1'b0;
      r_res_id        <= '0;
      r_res_data      <= '0;
      r_busy          <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      r_add_valid_in <= w_transfer;
      if (w_transfer) begin
        r_last     <= w_grant_id;
        r_add_dina <= w_sel_a;
        r_add_dinb <= w_sel_b;
        r_add_op   <= w_sel_op;
      end
      r_res_valid <= w_pop_ok;
      if (w_pop_ok) begin
        r_res_id   <= w_head;
        r_res_data <= add_result;
      end
      // Counting the pre-edge occupancy keeps busy up through the last result strobe.
      r_busy <= (w_count != '0) || w_transfer;
      if (add_valid_out && w_empty) r_err_underflow <= 1'b1;
    end
  end

  assign add_dina      = r_add_dina;
  assign add_dinb      = r_add_dinb;
  assign add_op        = r_add_op;
  assign add_valid_in  = r_add_valid_in;
  assign res_valid     = r_res_valid;
  assign res_id        = r_res_id;
  assign res_data      = r_res_data;
  assign busy          = r_busy;
  assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_fp32_addsub_arbiter.sv
// tb/tb_fp32_addsub_arbiter.sv - directed bench with a latency-3 adder model and result scoreboard
module tb_fp32_addsub_arbiter;
  import fp32_addsub_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*32-1:0]    req_a;
  logic [NREQ*32-1:0]    req_b;
  logic [NREQ-1:0]       req_op;
  logic [NREQ-1:0]       req_ready;
  logic                  hold;
  logic [31:0]           add_dina;
  logic [31:0]           add_dinb;
  logic                  add_op;
  logic                  add_valid_in;
  logic [31:0]           add_result;
  logic                  add_valid_out;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [31:0]           res_data;
  logic                  busy;
  logic                  err_underflow;

  logic                  stall;
  logic                  spur;
  int                    total = 0;
  int                    bad = 0;
  int                    mcyc = 0;
  logic [31:0]           pend_d[$];
  int                    pend_due[$];
  logic [IDW-1:0]        gold_id[$];
  logic [31:0]           gold_d[$];
  logic [31:0]           exp_t2 [4] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};

  always #5 clk = ~clk;

  fp32_addsub_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_op        (req_op),
    .req_ready     (req_ready),
    .hold          (hold),
    .add_dina      (add_dina),
    .add_dinb      (add_dinb),
    .add_op        (add_op),
    .add_valid_in  (add_valid_in),
    .add_result    (add_result),
    .add_valid_out (add_valid_out),
    .res_valid     (res_valid),
    .res_id        (res_id),
    .res_data      (res_data),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  // Hand-evaluated fp32 results for the directed vectors; other operands get an opaque tag.
  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (op == OP_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (op == OP_SUB && b == 32'h3F80_0000) begin
      if (a == 32'h3F80_0000) return 32'h0000_0000;
      if (a == 32'h4000_0000) return 32'h3F80_0000;
      if (a == 32'h4040_0000) return 32'h4000_0000;
      if (a == 32'h4080_0000) return 32'h4040_0000;
    end
    return a ^ {b[15:0], b[31:16]} ^ {31'b0, op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i] = op;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 64'(busy), 64'h0);
    chk({tag, "_drained"}, 64'(gold_id.size()), 64'h0);
  endtask

  // Adder model: latency 3 from add_valid_in, optional stall, optional spurious strobe.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_d.delete();
      pend_due.delete();
      add_valid_out <= 1'b0;
      add_result <= 32'h0;
    end else begin
      if (spur) begin
        add_valid_out <= 1'b1;
        add_result <= 32'hDEAD_BEEF;
      end else if (!stall && pend_due.size() != 0 && pend_due[0] <= mcyc) begin
        add_valid_out <= 1'b1;
        add_result <= pend_d.pop_front();
        void'(pend_due.pop_front());
      end else begin
        add_valid_out <= 1'b0;
      end
      if (add_valid_in) begin
        pend_d.push_back(fmodel(add_dina, add_dinb, add_op));
        pend_due.push_back(mcyc + 2);
      end
      mcyc <= mcyc + 1;
    end
  end

  always @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          gold_id.push_back(IDW'(i));
          gold_d.push_back(fmodel(req_a[i*32 +: 32], req_b[i*32 +: 32], req_op[i]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      gold_id.delete();
      gold_d.delete();
    end else if (res_valid) begin
      chk("sb_expected", 64'(gold_id.size() != 0), 64'h1);
      if (gold_id.size() != 0) begin
        chk("sb_id", 64'(res_id), 64'(gold_id.pop_front()));
        chk("sb_data", 64'(res_data), 64'(gold_d.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    rstn = 1'b0; hold = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    stall = 1'b0; spur = 1'b0;
    repeat (2) @(negedge clk);
    #1 req_valid = 4'hF;
    #1 chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_avi", 64'(add_valid_in), 64'h0);
    chk("rst_res_valid", 64'(res_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_err", 64'(err_underflow), 64'h0);
    chk("rst_dina", 64'(add_dina), 64'h0);
    req_valid = '0;
    @(negedge clk); #1 rstn = 1'b1;

    // single request: 1.0 + 2.0
    @(negedge clk); #1;
    set_slot(0, 32'h3F80_0000, 32'h4000_0000, OP_ADD);
    req_valid = 4'b0001;
    #1 chk("t1_ready", 64'(req_ready), 64'h1);
    @(negedge clk);
    chk("t1_avi", 64'(add_valid_in), 64'h1);
    chk("t1_dina", 64'(add_dina), 64'h3F80_0000);
    chk("t1_dinb", 64'(add_dinb), 64'h4000_0000);
    chk("t1_op", 64'(add_op), 64'h0);
    chk("t1_busy", 64'(busy), 64'h1);
    #1 req_valid = '0;
    @(negedge clk);
    chk("t1_avi_low", 64'(add_valid_in), 64'h0);
    repeat (2) @(negedge clk);
    chk("t1_res_early", 64'(res_valid), 64'h0);
    @(negedge clk);
    chk("t1_res_valid", 64'(res_valid), 64'h1);
    chk("t1_res_id", 64'(res_id), 64'h0);
    chk("t1_res_data", 64'(res_data), 64'h4040_0000);
    chk("t1_busy_hold", 64'(busy), 64'h1);
    @(negedge clk);
    chk("t1_res_pulse", 64'(res_valid), 64'h0);
    chk("t1_busy_fall", 64'(busy), 64'h0);
    wait_idle("t1");

    // fresh pointer, all four valid: (i+1.0) - 1.0
    @(negedge clk); #1 rstn = 1'b0;
    @(negedge clk); #1 rstn = 1'b1;
    @(negedge clk); #1;
    set_slot(0, 32'h3F80_0000, 32'h3F80_0000, OP_SUB);
    set_slot(1, 32'h4000_0000, 32'h3F80_0000, OP_SUB);
    set_slot(2, 32'h4040_0000, 32'h3F80_0000, OP_SUB);
    set_slot(3, 32'h4080_0000, 32'h3F80_0000, OP_SUB);
    req_valid = 4'hF;
    #1 chk("t2_ready0", 64'(req_ready), 64'h1);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k >= 5 && k <= 12) begin
        chk("t2_res_valid", 64'(res_valid), 64'h1);
        chk("t2_res_id", 64'(res_id), 64'((k - 5) % 4));
        chk("t2_res_data", 64'(res_data), 64'(exp_t2[(k - 5) % 4]));
      end
      if (k == 13) chk("t2_res_end", 64'(res_valid), 64'h0);
      #1 if (k == 8) req_valid = '0;
      #1 if (k < 8) chk("t2_ready", 64'(req_ready), 64'(1 << (k % 4)));
    end
    wait_idle("t2");

    // stalled adder fills the tag FIFO
    @(negedge clk); #1;
    stall = 1'b1;
    for (int i = 0; i < NREQ; i++) set_slot(i, 32'h0100_0005 + 32'(i) * 32'h0100_0000, 32'h0000_1234 + 32'(i), OP_ADD);
    req_valid = 4'b0101;
    #1 chk("t3_ready0", 64'(req_ready), 64'h1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); #2;
      chk("t3_ready", 64'(req_ready), (k % 2 == 1) ? 64'h4 : 64'h1);
    end
    for (int k = 8; k <= 10; k++) begin
      @(negedge clk); #2;
      chk("t3_full_ready", 64'(req_ready), 64'h0);
    end
    chk("t3_full_busy", 64'(busy), 64'h1);
    stall = 1'b0;
    @(negedge clk);
    chk("t3_pop_strobe", 64'(add_valid_out), 64'h1);
    #2 chk("t3_pop_same_cycle", 64'(req_ready), 64'h0);
    @(negedge clk); #2 chk("t3_resume", 64'(req_ready), 64'h1);
    @(negedge clk); #2 chk("t3_resume2", 64'(req_ready), 64'h4);
    @(negedge clk); #1 req_valid = '0;
    wait_idle("t3");

    // hold mid-stream
    @(negedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_slot(i, 32'h2000_0000 + 32'(i), 32'h0000_00A0 + 32'(i), OP_SUB);
    req_valid = 4'hF;
    #1 chk("t4_ready0", 64'(req_ready), 64'h8);
    @(negedge clk); #2 chk("t4_ready1", 64'(req_ready), 64'h1);
    @(negedge clk); #2 chk("t4_ready2", 64'(req_ready), 64'h2);
    @(negedge clk);
    chk("t4_avi_before_hold", 64'(add_valid_in), 64'h1);
    #1 hold = 1'b1;
    #1 chk("t4_hold_ready", 64'(req_ready), 64'h0);
    issued = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (add_valid_in) issued++;
      if (!busy) break;
    end
    chk("t4_no_issue", 64'(issued), 64'h0);
    chk("t4_busy_drained", 64'(busy), 64'h0);
    chk("t4_results_back", 64'(gold_id.size()), 64'h0);
    #1 hold = 1'b0;
    #1 chk("t4_resume_ptr", 64'(req_ready), 64'h4);
    @(negedge clk); #1 req_valid = '0;
    wait_idle("t4");

    // spurious adder strobe with nothing in flight
    @(negedge clk); #1 spur = 1'b1;
    @(negedge clk);
    chk("t5_err_before", 64'(err_underflow), 64'h0);
    #1 spur = 1'b0;
    @(negedge clk);
    chk("t5_no_res", 64'(res_valid), 64'h0);
    chk("t5_err_set", 64'(err_underflow), 64'h1);
    @(negedge clk);
    chk("t5_err_sticky", 64'(err_underflow), 64'h1);
    chk("t5_no_res2", 64'(res_valid), 64'h0);

    // reset with three operations in flight
    @(negedge clk); #1;
    set_slot(0, 32'h3F80_0000, 32'h4000_0000, OP_ADD);
    req_valid = 4'b0001;
    repeat (3) @(negedge clk);
    chk("t6_avi_pre", 64'(add_valid_in), 64'h1);
    chk("t6_busy_pre", 64'(busy), 64'h1);
    #1 req_valid = 4'b1010;
    #1 rstn = 1'b0;
    #1;
    chk("t6_ready", 64'(req_ready), 64'h0);
    chk("t6_avi", 64'(add_valid_in), 64'h0);
    chk("t6_dina", 64'(add_dina), 64'h0);
    chk("t6_op", 64'(add_op), 64'h0);
    chk("t6_res_valid", 64'(res_valid), 64'h0);
    chk("t6_res_data", 64'(res_data), 64'h0);
    chk("t6_busy", 64'(busy), 64'h0);
    chk("t6_err", 64'(err_underflow), 64'h0);
    @(negedge clk); #1 rstn = 1'b1;
    #1 chk("t6_first_req1", 64'(req_ready), 64'h2);
    @(negedge clk); #2 chk("t6_then_req3", 64'(req_ready), 64'h8);
    @(negedge clk); #1 req_valid = '0;
    wait_idle("t6");
    chk("t6_err_clear", 64'(err_underflow), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
